// File: rtl/pattern_pkg.sv
// Shared definitions for the multi-lane test pattern generator.
//   pattern_e  : pattern select codes (0 bars .. 7 zero)
//   LFSR_*     : PRBS polynomial taps and base seed (lane k seed = LFSR_SEED ^ k)
//   BAR_RGB    : colour-bar table; per bar, bit0=R, bit1=G, bit2=B
//   lfsr_next  : one step of the 16-bit Fibonacci LFSR
package pattern_pkg;

  typedef enum logic [2:0] {
    PT_BARS  = 3'd0,
    PT_HRAMP = 3'd1,
    PT_VRAMP = 3'd2,
    PT_CHECK = 3'd3,
    PT_SOLID = 3'd4,
    PT_MOVE  = 3'd5,
    PT_PRBS  = 3'd6,
    PT_ZERO  = 3'd7
  } pattern_e;

  localparam int          LFSR_W    = 16;
  // x^16 + x^14 + x^13 + x^11 + 1 -> feedback from bits 15,13,12,10
  localparam logic [15:0] LFSR_TAPS = 16'hB400;
  localparam logic [15:0] LFSR_SEED = 16'hACE1;

  // index 0 = leftmost bar: white, yellow, cyan, green, magenta, red, blue, black
  localparam logic [7:0][2:0] BAR_RGB = {
    3'b000, 3'b100, 3'b001, 3'b101, 3'b010, 3'b110, 3'b011, 3'b111
  };

  function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] s);
    return {s[LFSR_W-2:0], ^(s & LFSR_TAPS)};
  endfunction

endpackage

// File: rtl/pattern_gen_mc_lane.sv
// Per-lane pixel generator: stage-0 pattern compute, stage-1 data register.
//   in_pclk, in_rstn : clock, async active-low reset
//   x                : lane-0 x of the beat (this lane's pixel is x+LANE)
//   y_ramp, y_chk    : low line bits for the vertical ramp, line bit CHK_LOG2
//   act              : valid & de for this beat
//   frame_start      : vs rising edge this cycle (reloads the LFSR)
//   pat, solid, frame_cnt : effective pattern, solid colour and frame count
//   data             : registered lane pixel, NUM_CH channels of PIXEL_BIT
module pattern_lane
  import pattern_pkg::*;
#(
  parameter int PIXEL_BIT   = 8,
  parameter int FIFO_WIDTH  = 11,
  parameter int NUM_CH      = 3,
  parameter int H_ActivePix = 1920,
  parameter int CHK_LOG2    = 5,
  parameter int LANE        = 0
) (
  input  logic                        in_pclk,
  input  logic                        in_rstn,
  input  logic [FIFO_WIDTH-1:0]       x,
  input  logic [PIXEL_BIT-1:0]        y_ramp,
  input  logic                        y_chk,
  input  logic                        act,
  input  logic                        frame_start,
  input  pattern_e                    pat,
  input  logic [NUM_CH*PIXEL_BIT-1:0] solid,
  input  logic [7:0]                  frame_cnt,
  output logic [NUM_CH*PIXEL_BIT-1:0] data
);
  localparam int          PW    = FIFO_WIDTH + 1;   // x+LANE can step past the x range
  localparam int          BAR_W = H_ActivePix / 8;
  localparam logic [15:0] SEED  = LFSR_SEED ^ 16'(LANE);

  logic [PW-1:0]               px;
  logic [2:0]                  bar_idx;
  logic [2:0]                  rgb;
  logic [LFSR_W-1:0]           lfsr_q, lfsr_cur;
  logic [PIXEL_BIT-1:0]        hr, mv, prbs;
  logic                        chk;
  logic [NUM_CH*PIXEL_BIT-1:0] d;

  function automatic logic [PIXEL_BIT-1:0] rotl(input logic [PIXEL_BIT-1:0] v, input int r);
    logic [2*PIXEL_BIT-1:0] dbl;
    dbl = {v, v} << r;
    return dbl[2*PIXEL_BIT-1 -: PIXEL_BIT];
  endfunction

  assign px       = PW'(x) + PW'(LANE);
  assign hr       = PIXEL_BIT'(px);
  assign mv       = PIXEL_BIT'(px) + PIXEL_BIT'(frame_cnt);
  assign chk      = px[CHK_LOG2] ^ y_chk;
  // the frame-start beat already sees the fresh seed
  assign lfsr_cur = frame_start ? SEED : lfsr_q;
  assign prbs     = PIXEL_BIT'(lfsr_cur);

  always_comb begin
    bar_idx = '0;
    for (int i = 1; i < 8; i++)
      if (px >= PW'(i * BAR_W)) bar_idx = 3'(i);
    rgb = BAR_RGB[bar_idx];
    d   = '0;
    if (act) begin
      for (int c = 0; c < NUM_CH; c++) begin
        case (pat)
          PT_BARS:  d[c*PIXEL_BIT +: PIXEL_BIT] = {PIXEL_BIT{rgb[(c < 3) ? c : 0]}};
          PT_HRAMP: d[c*PIXEL_BIT +: PIXEL_BIT] = hr;
          PT_VRAMP: d[c*PIXEL_BIT +: PIXEL_BIT] = y_ramp;
          PT_CHECK: d[c*PIXEL_BIT +: PIXEL_BIT] = {PIXEL_BIT{chk}};
          PT_SOLID: d[c*PIXEL_BIT +: PIXEL_BIT] = solid[c*PIXEL_BIT +: PIXEL_BIT];
          PT_MOVE:  d[c*PIXEL_BIT +: PIXEL_BIT] = mv;
          PT_PRBS:  d[c*PIXEL_BIT +: PIXEL_BIT] = rotl(prbs, c % PIXEL_BIT);
          default:  d[c*PIXEL_BIT +: PIXEL_BIT] = '0;
        endcase
      end
    end
  end

  always_ff @(posedge in_pclk or negedge in_rstn) begin
    if (!in_rstn) begin
      data   <= '0;
      lfsr_q <= SEED;
    end else begin
      data   <= d;
      lfsr_q <= act ? lfsr_next(lfsr_cur) : lfsr_cur;
    end
  end

endmodule

// File: rtl/pattern_gen_mc.sv
// Multi-lane, multi-channel test pattern generator, 2-cycle fixed latency.
//   in_pclk, in_rstn           : pixel clock, async active-low reset
//   in_x/in_y/in_valid/in_de/in_hs/in_vs : upstream timing beat
//   in_pattern, in_solid       : pattern request / solid colour, taken at frame start
//   out_x..out_vs              : timing delayed by 2 cycles
//   out_data                   : PPC lanes of NUM_CH*PIXEL_BIT, aligned with out_*
//   out_frame_cnt              : frames started since reset, mod 256
module pattern_gen_mc
  import pattern_pkg::*;
#(
  parameter int PIXEL_BIT   = 8,
  parameter int FIFO_WIDTH  = 11,
  parameter int PPC         = 2,
  parameter int NUM_CH      = 3,
  parameter int H_ActivePix = 1920,
  parameter int V_ActivePix = 1080,
  parameter int CHK_LOG2    = 5
) (
  input  logic                            in_pclk,
  input  logic                            in_rstn,
  input  logic [FIFO_WIDTH-1:0]           in_x,
  input  logic [FIFO_WIDTH-1:0]           in_y,
  input  logic                            in_valid,
  input  logic                            in_de,
  input  logic                            in_hs,
  input  logic                            in_vs,
  input  logic [2:0]                      in_pattern,
  input  logic [NUM_CH*PIXEL_BIT-1:0]     in_solid,
  output logic [FIFO_WIDTH-1:0]           out_x,
  output logic [FIFO_WIDTH-1:0]           out_y,
  output logic                            out_valid,
  output logic                            out_de,
  output logic                            out_hs,
  output logic                            out_vs,
  output logic [PPC*NUM_CH*PIXEL_BIT-1:0] out_data,
  output logic [7:0]                      out_frame_cnt
);
  localparam int LW     = NUM_CH * PIXEL_BIT;
  localparam int STAGES = 2;

  typedef struct packed {
    logic [FIFO_WIDTH-1:0] x;
    logic [FIFO_WIDTH-1:0] y;
    logic                  valid;
    logic                  de;
    logic                  hs;
    logic                  vs;
  } ctrl_t;

  ctrl_t                   ctrl_in;
  ctrl_t [STAGES:1]        ctrl_pipe;
  logic                    vs_q, frame_start;
  pattern_e                pat_q, pat_eff;
  logic [LW-1:0]           solid_q, solid_eff;
  logic [7:0]              cnt_q, cnt_eff;
  logic [PIXEL_BIT-1:0]    y_ramp;
  logic [PPC-1:0][LW-1:0]  lane_d, data_q;

  assign ctrl_in     = '{x: in_x, y: in_y, valid: in_valid, de: in_de, hs: in_hs, vs: in_vs};
  assign frame_start = in_vs & ~vs_q;
  // a pixel on the frame-start beat already uses the new frame's settings
  assign pat_eff     = frame_start ? pattern_e'(in_pattern) : pat_q;
  assign solid_eff   = frame_start ? in_solid : solid_q;
  assign cnt_eff     = frame_start ? cnt_q + 8'd1 : cnt_q;
  assign y_ramp      = PIXEL_BIT'(in_y);

  for (genvar g = 0; g < PPC; g++) begin : g_lane
    pattern_lane #(
      .PIXEL_BIT(PIXEL_BIT), .FIFO_WIDTH(FIFO_WIDTH), .NUM_CH(NUM_CH),
      .H_ActivePix(H_ActivePix), .CHK_LOG2(CHK_LOG2), .LANE(g)
    ) u_lane (
      .in_pclk, .in_rstn,
      .x(in_x), .y_ramp, .y_chk(in_y[CHK_LOG2]),
      .act(in_valid & in_de), .frame_start,
      .pat(pat_eff), .solid(solid_eff), .frame_cnt(cnt_eff),
      .data(lane_d[g])
    );
  end

  always_ff @(posedge in_pclk or negedge in_rstn) begin
    if (!in_rstn) begin
      ctrl_pipe <= '0;
      data_q    <= '0;
      vs_q      <= 1'b0;
      pat_q     <= PT_BARS;
      solid_q   <= '0;
      cnt_q     <= '0;
    end else begin
      ctrl_pipe[1] <= ctrl_in;
      ctrl_pipe[2] <= ctrl_pipe[1];
      data_q       <= lane_d;
      vs_q         <= in_vs;
      if (frame_start) begin
        pat_q   <= pat_eff;
        solid_q <= in_solid;
        cnt_q   <= cnt_eff;
      end
    end
  end

  assign out_x         = ctrl_pipe[STAGES].x;
  assign out_y         = ctrl_pipe[STAGES].y;
  assign out_valid     = ctrl_pipe[STAGES].valid;
  assign out_de        = ctrl_pipe[STAGES].de;
  assign out_hs        = ctrl_pipe[STAGES].hs;
  assign out_vs        = ctrl_pipe[STAGES].vs;
  assign out_data      = data_q;
  assign out_frame_cnt = cnt_q;

endmodule

// File: tb/tb_pattern_gen_mc.sv
// Directed bench for pattern_gen_mc (PPC=2, NUM_CH=3, PIXEL_BIT=8).
// Each drive() call applies one beat and returns 1 time unit after the
// clock edge; at that point the outputs show the beat of the previous call.
module tb_pattern_gen_mc;
  logic        in_pclk = 1'b0;
  logic        in_rstn = 1'b0;
  logic [10:0] in_x = '0, in_y = '0;
  logic        in_valid = 1'b0, in_de = 1'b0, in_hs = 1'b0, in_vs = 1'b0;
  logic [2:0]  in_pattern = '0;
  logic [23:0] in_solid = '0;
  logic [10:0] out_x, out_y;
  logic        out_valid, out_de, out_hs, out_vs;
  logic [47:0] out_data;
  logic [7:0]  out_frame_cnt;

  int total = 0;
  int bad   = 0;

  typedef struct packed {
    logic [10:0] x;
    logic [10:0] y;
    logic        v, de, hs, vs;
  } beat_t;
  beat_t cur = '0, prv = '0;

  pattern_gen_mc dut (
    .in_pclk(in_pclk), .in_rstn(in_rstn), .in_x(in_x), .in_y(in_y),
    .in_valid(in_valid), .in_de(in_de), .in_hs(in_hs), .in_vs(in_vs),
    .in_pattern(in_pattern), .in_solid(in_solid),
    .out_x(out_x), .out_y(out_y), .out_valid(out_valid), .out_de(out_de),
    .out_hs(out_hs), .out_vs(out_vs), .out_data(out_data),
    .out_frame_cnt(out_frame_cnt)
  );

  always #5 in_pclk = ~in_pclk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  // raw lane word (ch0 in low byte)
  function automatic logic [23:0] lane(input int k);
    return out_data[k*24 +: 24];
  endfunction
  // lane written as R,G,B (ch0 first), matching how bar colours are quoted
  function automatic logic [23:0] rgb(input int k);
    return {out_data[k*24 +: 8], out_data[k*24+8 +: 8], out_data[k*24+16 +: 8]};
  endfunction

  task automatic drive(input int x, input int y, input logic v, de, hs, vs);
    prv = cur;
    cur.x = 11'(x); cur.y = 11'(y); cur.v = v; cur.de = de; cur.hs = hs; cur.vs = vs;
    in_x = 11'(x); in_y = 11'(y); in_valid = v; in_de = de; in_hs = hs; in_vs = vs;
    @(posedge in_pclk); #1;
  endtask

  task automatic new_frame(input logic [2:0] pat, input logic [23:0] sol);
    in_pattern = pat;
    in_solid   = sol;
    drive(0, 0, 0, 0, 0, 1);
    drive(0, 0, 0, 0, 0, 0);
  endtask

  task automatic test_reset();
    in_pattern = 3'd3;
    drive(5, 7, 1, 1, 1, 1);
    drive(6, 7, 1, 1, 1, 1);
    total++;
    if (out_data !== 48'h0) begin bad++; $display("FAIL rst_data got=%h exp=0", out_data); end
    total++;
    if ({out_x, out_y, out_valid, out_de, out_hs, out_vs} !== 26'h0) begin
      bad++; $display("FAIL rst_ctrl got=%h exp=0", {out_x, out_y, out_valid, out_de, out_hs, out_vs});
    end
    total++;
    if (out_frame_cnt !== 8'd0) begin bad++; $display("FAIL rst_cnt got=%0d exp=0", out_frame_cnt); end
    drive(0, 0, 0, 0, 0, 0);
    in_rstn = 1'b1;
    drive(0, 0, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 0, 0);
    total++;
    if (out_frame_cnt !== 8'd0) begin bad++; $display("FAIL rst_cnt_rel got=%0d exp=0", out_frame_cnt); end
  endtask

  // two lines of 1920 px of colour bars, every beat checked for the 2-cycle control lag
  task automatic test_bars();
    logic [23:0] bar_exp [8];
    bar_exp = '{24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
                24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000};
    new_frame(3'd0, 24'h0);
    for (int y = 0; y < 2; y++) begin
      for (int i = -2; i <= 960; i++) begin
        if (i < 0 || i == 960) drive(0, y, 0, 0, (i == -2), 0);
        else                   drive(2*i, y, 1, 1, 0, 0);
        total++;
        if ({out_x, out_y, out_valid, out_de, out_hs, out_vs} !==
            {prv.x, prv.y, prv.v, prv.de, prv.hs, prv.vs}) begin
          bad++;
          $display("FAIL ctrl_lag got=%h exp=%h", {out_x, out_y, out_valid, out_de, out_hs, out_vs},
                   {prv.x, prv.y, prv.v, prv.de, prv.hs, prv.vs});
        end
        if (!prv.de) begin
          total++;
          if (out_data !== 48'h0) begin bad++; $display("FAIL bars_blank got=%h exp=0", out_data); end
        end else if (prv.y == 0) begin
          for (int b = 0; b < 8; b++) begin
            if (prv.x == 11'(b*240)) begin
              total++;
              if (rgb(0) !== bar_exp[b]) begin
                bad++; $display("FAIL bar%0d got=%h exp=%h", b, rgb(0), bar_exp[b]);
              end
            end
          end
          if (prv.x == 11'd238) begin
            total++;
            if (rgb(1) !== 24'hFFFFFF) begin bad++; $display("FAIL bar_px239 got=%h exp=ffffff", rgb(1)); end
          end
          if (prv.x == 11'd1918) begin
            total++;
            if (rgb(1) !== 24'h000000) begin bad++; $display("FAIL bar_px1919 got=%h exp=000000", rgb(1)); end
          end
        end
      end
    end
    total++;
    if (out_frame_cnt !== 8'd1) begin bad++; $display("FAIL bars_cnt got=%0d exp=1", out_frame_cnt); end
  endtask

  task automatic test_hramp();
    new_frame(3'd1, 24'h0);
    drive(254, 5, 1, 1, 0, 0);
    drive(256, 5, 1, 1, 0, 0);
    total++;
    if (lane(0) !== 24'hFEFEFE) begin bad++; $display("FAIL hr254_l0 got=%h exp=fefefe", lane(0)); end
    total++;
    if (lane(1) !== 24'hFFFFFF) begin bad++; $display("FAIL hr255_l1 got=%h exp=ffffff", lane(1)); end
    drive(0, 0, 0, 0, 0, 0);
    total++;
    if (lane(0) !== 24'h000000) begin bad++; $display("FAIL hr256_l0 got=%h exp=000000", lane(0)); end
    total++;
    if (lane(1) !== 24'h010101) begin bad++; $display("FAIL hr257_l1 got=%h exp=010101", lane(1)); end
    total++;
    if (out_frame_cnt !== 8'd2) begin bad++; $display("FAIL hr_cnt got=%0d exp=2", out_frame_cnt); end
  endtask

  task automatic test_switch();
    new_frame(3'd3, 24'h0);
    drive(0, 0, 1, 1, 0, 0);
    drive(32, 0, 1, 1, 0, 0);
    total++;
    if (out_data !== 48'h0) begin bad++; $display("FAIL chk_x0 got=%h exp=0", out_data); end
    drive(0, 32, 1, 1, 0, 0);
    total++;
    if (out_data !== {2{24'hFFFFFF}}) begin bad++; $display("FAIL chk_x32 got=%h exp=all ones", out_data); end
    drive(30, 0, 1, 1, 0, 0);
    total++;
    if (out_data !== {2{24'hFFFFFF}}) begin bad++; $display("FAIL chk_y32 got=%h exp=all ones", out_data); end
    // mid-frame request change must not take effect yet
    in_pattern = 3'd4;
    in_solid   = 24'h123456;
    drive(32, 32, 1, 1, 0, 0);
    total++;
    if (out_data !== 48'h0) begin bad++; $display("FAIL chk_x30 got=%h exp=0", out_data); end
    drive(32, 0, 1, 1, 0, 0);
    total++;
    if (out_data !== 48'h0) begin bad++; $display("FAIL chk_hold_a got=%h exp=0", out_data); end
    drive(0, 0, 0, 0, 0, 0);
    total++;
    if (out_data !== {2{24'hFFFFFF}}) begin bad++; $display("FAIL chk_hold_b got=%h exp=all ones", out_data); end
    // frame start on an active beat: solid applies to that beat
    drive(64, 0, 1, 1, 0, 1);
    in_solid = 24'h654321;
    drive(0, 0, 1, 1, 0, 0);
    total++;
    if (out_data !== {2{24'h123456}}) begin bad++; $display("FAIL solid_fs got=%h exp=123456 x2", out_data); end
    drive(0, 0, 0, 0, 0, 0);
    total++;
    if (out_data !== {2{24'h123456}}) begin bad++; $display("FAIL solid_hold got=%h exp=123456 x2", out_data); end
    total++;
    if (out_frame_cnt !== 8'd4) begin bad++; $display("FAIL sw_cnt got=%0d exp=4", out_frame_cnt); end
  endtask

  task automatic test_prbs();
    for (int f = 0; f < 2; f++) begin
      new_frame(3'd6, 24'h0);
      drive(0, 0, 1, 1, 0, 0);
      drive(2, 0, 1, 0, 0, 0);
      total++;
      if (rgb(0) !== 24'hE1C387) begin bad++; $display("FAIL prbs%0d_b0_l0 got=%h exp=e1c387", f, rgb(0)); end
      total++;
      if (lane(1)[7:0] !== 8'hE0) begin bad++; $display("FAIL prbs%0d_b0_l1 got=%h exp=e0", f, lane(1)[7:0]); end
      drive(4, 0, 1, 1, 0, 0);
      total++;
      if (out_data !== 48'h0) begin bad++; $display("FAIL prbs%0d_de0 got=%h exp=0", f, out_data); end
      drive(6, 0, 1, 1, 0, 0);
      total++;
      if (lane(0)[7:0] !== 8'hC3) begin bad++; $display("FAIL prbs%0d_b1_l0 got=%h exp=c3", f, lane(0)[7:0]); end
      total++;
      if (lane(1)[7:0] !== 8'hC1) begin bad++; $display("FAIL prbs%0d_b1_l1 got=%h exp=c1", f, lane(1)[7:0]); end
      drive(0, 0, 0, 0, 0, 0);
      total++;
      if (lane(0)[7:0] !== 8'h87) begin bad++; $display("FAIL prbs%0d_b2_l0 got=%h exp=87", f, lane(0)[7:0]); end
    end
  endtask

  task automatic test_reset_mid();
    new_frame(3'd2, 24'h0);
    drive(0, 3, 1, 1, 0, 0);
    drive(2, 3, 1, 1, 0, 0);
    total++;
    if (lane(0) !== 24'h030303) begin bad++; $display("FAIL vramp got=%h exp=030303", lane(0)); end
    #2;
    in_rstn = 1'b0;
    #1;
    total++;
    if (out_data !== 48'h0) begin bad++; $display("FAIL rmid_data got=%h exp=0", out_data); end
    total++;
    if ({out_x, out_y, out_valid, out_de, out_hs, out_vs, out_frame_cnt} !== 34'h0) begin
      bad++; $display("FAIL rmid_ctrl got=%h exp=0", {out_x, out_y, out_valid, out_de, out_hs, out_vs, out_frame_cnt});
    end
    drive(4, 3, 1, 1, 0, 0);
    in_rstn = 1'b1;
    drive(0, 3, 1, 1, 0, 0);
    drive(480, 3, 1, 1, 0, 0);
    total++;
    if (rgb(0) !== 24'hFFFFFF) begin bad++; $display("FAIL rmid_bars_x0 got=%h exp=ffffff", rgb(0)); end
    drive(0, 0, 0, 0, 0, 0);
    total++;
    if (rgb(0) !== 24'h00FFFF) begin bad++; $display("FAIL rmid_bars_x480 got=%h exp=00ffff", rgb(0)); end
    new_frame(3'd2, 24'h0);
    drive(0, 3, 1, 1, 0, 0);
    drive(0, 0, 0, 0, 0, 0);
    total++;
    if (lane(0) !== 24'h030303) begin bad++; $display("FAIL rmid_vramp got=%h exp=030303", lane(0)); end
    total++;
    if (out_frame_cnt !== 8'd1) begin bad++; $display("FAIL rmid_cnt got=%0d exp=1", out_frame_cnt); end
  endtask

  task automatic test_moving();
    logic [7:0] e0, e1;
    in_rstn = 1'b0;
    drive(0, 0, 0, 0, 0, 0);
    in_rstn = 1'b1;
    for (int f = 1; f <= 3; f++) begin
      new_frame(3'd5, 24'h0);
      drive(10, 0, 1, 1, 0, 0);
      drive(0, 0, 0, 0, 0, 0);
      e0 = 8'(10 + f);
      e1 = 8'(11 + f);
      total++;
      if (lane(0) !== {3{e0}}) begin bad++; $display("FAIL move_f%0d_l0 got=%h exp=%h", f, lane(0), {3{e0}}); end
      total++;
      if (lane(1) !== {3{e1}}) begin bad++; $display("FAIL move_f%0d_l1 got=%h exp=%h", f, lane(1), {3{e1}}); end
    end
    for (int f = 4; f <= 255; f++) new_frame(3'd5, 24'h0);
    total++;
    if (out_frame_cnt !== 8'd255) begin bad++; $display("FAIL cnt255 got=%0d exp=255", out_frame_cnt); end
    new_frame(3'd5, 24'h0);
    total++;
    if (out_frame_cnt !== 8'd0) begin bad++; $display("FAIL cnt_wrap got=%0d exp=0", out_frame_cnt); end
  endtask

  initial begin
    test_reset();
    test_bars();
    test_hramp();
    test_switch();
    test_prbs();
    test_reset_mid();
    test_moving();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pattern_gen_mc.md
Name: pattern_gen_mc

Overview:
Multi-lane, multi-channel test pattern generator for the CSI-RX display/verification path. It takes timing (x, y, valid, de, hs, vs) from the upstream VGA-style timing generator. It emits PPC pixels per clock, each with NUM_CH colour channels, with sync delayed to match the data. Adds frame-synchronous pattern switching, a frame counter, animated and PRBS modes, and a programmable solid colour.

Parameters:
PIXEL_BIT, 8, bits per colour channel
FIFO_WIDTH, 11, width of x/y coordinates
PPC, 2, pixels per clock (lanes), 1..4
NUM_CH, 3, colour channels per pixel (ch0=R, ch1=G, ch2=B; ch>=3 copy ch0)
H_ActivePix, 1920, active width, multiple of 8*PPC
V_ActivePix, 1080, active height
CHK_LOG2, 5, checkerboard square size = 2^CHK_LOG2 pixels

Ports:
in_pclk  input  1  pixel clock
in_rstn  input  1  reset, asynchronous, active-low
in_x  input  FIFO_WIDTH  x of lane 0 pixel; lane k pixel is in_x+k
in_y  input  FIFO_WIDTH  line index
in_valid  input  1  timing beat valid
in_de  input  1  active-video enable
in_hs  input  1  hsync
in_vs  input  1  vsync, active-high
in_pattern  input  3  requested pattern, sampled at frame start
in_solid  input  NUM_CH*PIXEL_BIT  solid colour, sampled at frame start
out_x, out_y  output  FIFO_WIDTH  delayed in_x/in_y
out_valid, out_de, out_hs, out_vs  output  1 each  delayed controls
out_data  output  PPC*NUM_CH*PIXEL_BIT  lane k at [k*NUM_CH*PIXEL_BIT +: NUM_CH*PIXEL_BIT], channel c within lane at [c*PIXEL_BIT +: PIXEL_BIT]
out_frame_cnt  output  8  frames started since reset, mod 256

Behaviour:
- Clock in_pclk. Reset in_rstn is asynchronous and active-low. While in reset, all outputs, pipeline registers, active pattern (0), latched solid, frame counter and LFSRs are 0 / seed.
- Pipeline: fixed 2-cycle latency on every output including controls. No stall; it advances every clock. Controls and x/y pass through 2 register stages unmodified.
- Frame start = rising edge of in_vs (in_vs=1, registered in_vs=0). On that cycle: active pattern <= in_pattern; solid <= in_solid; out_frame_cnt += 1 (255 wraps to 0); every lane LFSR reloads its seed. Mid-frame changes of in_pattern/in_solid are ignored until the next frame start.
- When in_de=0 or in_valid=0 at stage 0, the lane data is all zero.
- Active patterns, per lane, with px = in_x+k:
  - 0 colour bars: 8 equal bars of width H_ActivePix/8, selected by constant compares, no divider. Order: white, yellow, cyan, green, magenta, red, blue, black. Each channel is all-ones or 0.
  - 1 horizontal ramp: every channel = px mod 2^PIXEL_BIT.
  - 2 vertical ramp: every channel = in_y mod 2^PIXEL_BIT.
  - 3 checkerboard: bit CHK_LOG2 of px XOR bit CHK_LOG2 of in_y. 1 gives all-ones, 0 gives 0.
  - 4 solid: latched in_solid.
  - 5 moving ramp: every channel = (px + frame_cnt) mod 2^PIXEL_BIT.
  - 6 PRBS: per-lane 16-bit Fibonacci LFSR x^16+x^14+x^13+x^11+1. Seed for lane k = 16'hACE1 ^ k. Advances once per cycle with in_valid&in_de. Channel c = LFSR low PIXEL_BIT bits rotated left by c.
  - 7 zero: all data 0.
- Frame start and active pixel on the same cycle: the new pattern applies to that pixel.
- Reset asserted mid-frame: outputs go to 0 immediately. After release, the first frame start is required before the pattern changes from 0.

Decomposition:
- Shared package pattern_pkg holds:
  - pattern code constants PT_BARS..PT_ZERO;
  - LFSR polynomial and base seed;
  - bar colour table.
- One sub-module, pattern_lane: per-lane generator with stage-0 compute and stage-1 register, instantiated PPC times via generate.
- The top holds the vs-edge detector, pattern/solid latches, frame counter and control delay line.

Test Plan:
- Reset release, PPC=2, pattern request 0, one full 1920x1080 frame.
  - out_frame_cnt = 1.
  - At x=0 the lane 0 data is 0xFFFFFF.
  - At x=240 it is 0xFFFF00 (R,G,B = FF,FF,00).
  - At x=1918 lane 1 (px=1919) is 0x000000.
  - All controls lag by exactly 2 cycles.
- Pattern 1: beat with in_x=254 -> lane 0 = 0xFEFEFE, lane 1 = 0xFFFFFF. Beat with in_x=256 -> lane 0 = 0x000000 (wrap).
- in_pattern changed from 3 to 4 mid-frame, in_solid = 0x123456:
  - output stays checkerboard until the next vs rising edge;
  - after it, every active pixel is 0x123456.
- Pattern 5 over 3 frames: pixel x=10,y=0 = 11, 12, 13. After 256 frames out_frame_cnt wraps to 0.
- Pattern 6: the first active beat after each frame start gives lane 0 = 0xE1 on ch0 (seed low byte), and the PRBS sequence is identical in consecutive frames. in_de=0 beats give zero data and do not advance the LFSR.
- Reset asserted mid-line: all outputs read 0 in the same cycle. After release, the pattern is 0 (bars) until the next frame start.
